// File: rtl/sram_like_arbiter_if.sv
// sram-like bus bundle (req / addr_ok / data_ok) with N request lanes.
// The arbiter takes an N-lane upstream port and a 1-lane downstream port.
// cancel is only consumed when SRAM_ARB_CANCEL_EN is defined.
interface sram_like_arbiter_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [N-1:0]            req;
  logic [N-1:0]            wr;
  logic [2*N-1:0]          size;
  logic [N*DATA_W/8-1:0]   wstrb;
  logic [N*ADDR_W-1:0]     addr;
  logic [N*DATA_W-1:0]     wdata;
  logic [N-1:0]            cancel;
  logic [N-1:0]            addr_ok;
  logic [N-1:0]            data_ok;
  logic [DATA_W-1:0]       rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata, cancel,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata, cancel,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// N-to-1 sram-like bus arbiter: round-robin grant held until the address
// handshake, plus an in-order FIFO routing each data_ok back to its channel.
// Optional macro SRAM_ARB_CANCEL_EN adds a per-entry drop bit so a master
// can discard its in-flight responses via m.cancel.
module sram_like_arbiter #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  sram_like_arbiter_if.slave          m,
  sram_like_arbiter_if.master         s,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt,
  output logic                        err_spurious
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W  = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [0:0] {StIdle, StLocked} lock_state_e;

  lock_state_e      r_state;
  logic [CH_W-1:0]  r_rr_ptr;
  logic [CH_W-1:0]  r_locked_ch;
  logic [CH_W-1:0]  r_fifo_ch [MAX_OUTST];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [CH_W-1:0]  w_scan_ch;
  logic [CH_W-1:0]  w_grant;
  logic [CH_W-1:0]  w_sel;
  logic [CH_W-1:0]  w_rr_next;
  logic [CH_W-1:0]  w_head;
  logic             w_any_req;
  logic             w_full;
  logic             w_empty;
  logic             w_s_req;
  logic             w_push;
  logic             w_pop;
  logic             w_head_drop;

  // Round-robin scan: first requesting channel at or after r_rr_ptr.
  always_comb begin : scan
    logic [CH_W:0] w_idx;
    logic          w_hit;
    w_scan_ch = '0;
    w_hit     = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
      if (w_idx >= (CH_W+1)'(NUM_CH)) w_idx = w_idx - (CH_W+1)'(NUM_CH);
      if (!w_hit && m.req[w_idx[CH_W-1:0]]) begin
        w_hit     = 1'b1;
        w_scan_ch = w_idx[CH_W-1:0];
      end
    end
  end

  assign w_any_req = |m.req;
  assign w_grant   = (r_state == StLocked) ? r_locked_ch : w_scan_ch;
  assign w_rr_next = (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
  assign w_full    = (r_cnt == CNT_W'(MAX_OUTST));
  assign w_empty   = (r_cnt == '0);
  // No same-cycle bypass when full: a freed slot is only usable next cycle.
  assign w_s_req   = ((r_state == StLocked) | w_any_req) & ~w_full;
  assign w_push    = w_s_req & s.addr_ok[0];
  assign w_pop     = s.data_ok[0] & ~w_empty;
  assign w_head    = r_fifo_ch[r_rptr];
  // Idle payload is taken from channel 0.
  assign w_sel     = w_s_req ? w_grant : '0;

  // Downstream payload mux and upstream handshake routing.
  always_comb begin
    s.req     = w_s_req;
    s.wr      = m.wr[w_sel];
    s.size    = m.size[w_sel*2 +: 2];
    s.wstrb   = m.wstrb[w_sel*STRB_W +: STRB_W];
    s.addr    = m.addr[w_sel*ADDR_W +: ADDR_W];
    s.wdata   = m.wdata[w_sel*DATA_W +: DATA_W];
    s.cancel  = '0;
    m.addr_ok = w_push ? (NUM_CH'(1) << w_grant) : '0;
    m.data_ok = (w_pop && !w_head_drop) ? (NUM_CH'(1) << w_head) : '0;
    m.rdata   = s.rdata;
  end

  assign outst_cnt    = r_cnt;
  assign err_spurious = r_err;

  // Grant lock: hold the granted channel until its address is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_locked_ch <= '0;
      r_rr_ptr    <= '0;
    end else if (w_push) begin
      r_state  <= StIdle;
      r_rr_ptr <= w_rr_next;
    end else if (w_s_req) begin
      r_state     <= StLocked;
      r_locked_ch <= w_grant;
    end
  end

  // Outstanding-order FIFO and sticky spurious-response flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int e = 0; e < MAX_OUTST; e++) r_fifo_ch[e] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_ch[r_wptr] <= w_grant;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      if (s.data_ok[0] && w_empty) r_err <= 1'b1;
    end
  end

`ifdef SRAM_ARB_CANCEL_EN
  logic                 r_drop [MAX_OUTST];
  logic [MAX_OUTST-1:0] w_valid;

  // An entry is live if its distance from the read pointer is below the count.
  always_comb begin
    logic [PTR_W-1:0] w_off;
    w_off = '0;
    for (int e = 0; e < MAX_OUTST; e++) begin
      w_off      = PTR_W'(e) - r_rptr;
      w_valid[e] = ({1'b0, w_off} < r_cnt);
    end
  end

  assign w_head_drop = r_drop[r_rptr];

  // Mark live entries of a cancelling channel; a same-cycle push inherits it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int e = 0; e < MAX_OUTST; e++) r_drop[e] <= 1'b0;
    end else begin
      for (int e = 0; e < MAX_OUTST; e++) begin
        if (w_valid[e] && m.cancel[r_fifo_ch[e]]) r_drop[e] <= 1'b1;
      end
      if (w_push) r_drop[r_wptr] <= m.cancel[w_grant];
    end
  end
`else
  logic w_unused_cancel;
  assign w_unused_cancel = ^m.cancel;
  assign w_head_drop     = 1'b0;
`endif
endmodule
